// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback and counts retirements.
module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             InstrDone,
    output logic             Illegal,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQ     = 4'd8,
        S_JUMP    = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [CNT_W-1:0] r_count;
    state_t           w_next;
    logic             w_op_legal;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.instr_done = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write  = 1'b1;
                c.iord       = 1'b1;
                c.instr_done = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RTYPEWB: begin
                c.reg_write  = 1'b1;
                c.reg_dst    = 1'b1;
                c.instr_done = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                c.instr_done    = 1'b1;
            end
            S_JUMP: begin
                c.pc_write   = 1'b1;
                c.pc_source  = 2'b10;
                c.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                c.reg_write  = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_op_legal = 1'b0;
        case (Op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: w_op_legal = 1'b1;
            default:                                       w_op_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_RTYPEWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    // Control outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= decode_ctrl(S_FETCH);
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_ctrl(w_next);
            if (r_ctrl.instr_done)
                r_count <= r_count + CNT_W'(1);
        end
    end

    // Write-type strobes are gated by reset so an aborted instruction cannot disturb state.
    assign PCWrite     = r_ctrl.pc_write      & ~reset;
    assign PCWriteCond = r_ctrl.pc_write_cond & ~reset;
    assign MemRead     = r_ctrl.mem_read      & ~reset;
    assign MemWrite    = r_ctrl.mem_write     & ~reset;
    assign IRWrite     = r_ctrl.ir_write      & ~reset;
    assign RegWrite    = r_ctrl.reg_write     & ~reset;
    assign InstrDone   = r_ctrl.instr_done    & ~reset;
    assign Illegal     = (r_state == S_DECODE) & ~w_op_legal & ~reset;

    assign IorD        = r_ctrl.iord;
    assign MemtoReg    = r_ctrl.mem_to_reg;
    assign PCSource    = r_ctrl.pc_source;
    assign ALUOp       = r_ctrl.alu_op;
    assign ALUSrcA     = r_ctrl.alu_src_a;
    assign ALUSrcB     = r_ctrl.alu_src_b;
    assign RegDst      = r_ctrl.reg_dst;
    assign State       = r_state;
    assign InstrCount  = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: vector table, hand sequences and random programs.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  Op;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0]  PCSource, ALUOp, ALUSrcB;
    logic        ALUSrcA, RegWrite, RegDst, InstrDone, Illegal;
    logic [3:0]  State;
    logic [15:0] InstrCount;

    logic        s_PCWrite, s_PCWriteCond, s_IorD, s_MemRead, s_MemWrite, s_MemtoReg, s_IRWrite;
    logic [1:0]  s_PCSource, s_ALUOp, s_ALUSrcB;
    logic        s_ALUSrcA, s_RegWrite, s_RegDst, s_InstrDone, s_Illegal;
    logic [3:0]  s_State;
    logic [3:0]  s_InstrCount;

    multicycle_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .InstrDone(InstrDone), .Illegal(Illegal), .State(State),
        .InstrCount(InstrCount)
    );

    // Narrow-counter copy lets the wrap-around be exercised in a handful of instructions.
    multicycle_control #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(s_PCWrite), .PCWriteCond(s_PCWriteCond), .IorD(s_IorD), .MemRead(s_MemRead),
        .MemWrite(s_MemWrite), .MemtoReg(s_MemtoReg), .IRWrite(s_IRWrite), .PCSource(s_PCSource),
        .ALUOp(s_ALUOp), .ALUSrcA(s_ALUSrcA), .ALUSrcB(s_ALUSrcB), .RegWrite(s_RegWrite),
        .RegDst(s_RegDst), .InstrDone(s_InstrDone), .Illegal(s_Illegal), .State(s_State),
        .InstrCount(s_InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite | PCSource | ALUOp | ALUSrcA | ALUSrcB | RegWrite,RegDst,InstrDone}
    logic [16:0] w_outs;
    assign w_outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, InstrDone};

    localparam logic [16:0] OUT_RESET = 17'b0000000_00_00_0_01_000;

    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;

    typedef struct {
        logic [5:0]       op;
        int               len;
        logic [4:0][3:0]  seq;
    } vec_t;

    vec_t tab[8];

    function automatic logic [16:0] exp_out(input logic [3:0] s);
        case (s)
            4'd0:    return 17'b1001001_00_00_0_01_000;
            4'd1:    return 17'b0000000_00_00_0_11_000;
            4'd2:    return 17'b0000000_00_00_1_10_000;
            4'd3:    return 17'b0011000_00_00_0_00_000;
            4'd4:    return 17'b0000010_00_00_0_00_101;
            4'd5:    return 17'b0010100_00_00_0_00_001;
            4'd6:    return 17'b0000000_00_10_1_00_000;
            4'd7:    return 17'b0000000_00_00_0_00_111;
            4'd8:    return 17'b0100000_01_01_1_00_001;
            4'd9:    return 17'b1000000_10_00_0_00_001;
            4'd10:   return 17'b0000000_00_00_1_10_000;
            4'd11:   return 17'b0000000_00_00_0_00_101;
            default: return 17'b0;
        endcase
    endfunction

    function automatic bit supported(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Instruction-level reference: the list of states an opcode walks through.
    function automatic int ref_seq(input logic [5:0] op, output logic [4:0][3:0] seq);
        seq = '0;
        seq[1] = 4'd1;
        case (op)
            6'b100011: begin seq[2] = 4'd2;  seq[3] = 4'd3;  seq[4] = 4'd4; return 5; end
            6'b101011: begin seq[2] = 4'd2;  seq[3] = 4'd5;  return 4; end
            6'b000000: begin seq[2] = 4'd6;  seq[3] = 4'd7;  return 4; end
            6'b001000: begin seq[2] = 4'd10; seq[3] = 4'd11; return 4; end
            6'b000100: begin seq[2] = 4'd8;  return 3; end
            6'b000010: begin seq[2] = 4'd9;  return 3; end
            default:   return 2;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Called at a falling edge; compares everything for one expected state.
    task automatic check_cycle(input logic [3:0] s, input logic [5:0] op);
        logic [16:0] e;
        #1;
        e = exp_out(s);
        chk("state", 32'(State), 32'(s));
        chk("outputs", 32'(w_outs), 32'(e));
        chk("illegal", 32'(Illegal), 32'((s == 4'd1) && !supported(op)));
        chk("count", 32'(InstrCount), 32'(model_cnt[15:0]));
        chk("small_state", 32'(s_State), 32'(s));
        chk("small_count", 32'(s_InstrCount), 32'(model_cnt[3:0]));
        if (e[0]) model_cnt++;
    endtask

    task automatic run_seq(input logic [5:0] op, input int len, input logic [4:0][3:0] seq,
                           input bit jitter);
        for (int i = 0; i < len; i++) begin
            if (seq[i] == 4'd1 || seq[i] == 4'd2 || !jitter) Op = op;
            else Op = 6'($urandom);
            check_cycle(seq[i], op);
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [5:0] op, input bit jitter);
        logic [4:0][3:0] seq;
        int len;
        len = ref_seq(op, seq);
        run_seq(op, len, seq, jitter);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [5:0] op;
        int start_cnt;

        tab[0] = '{6'b100011, 5, {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}};
        tab[1] = '{6'b101011, 4, {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}};
        tab[2] = '{6'b000000, 4, {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}};
        tab[3] = '{6'b000100, 3, {4'd0, 4'd0, 4'd8, 4'd1, 4'd0}};
        tab[4] = '{6'b000010, 3, {4'd0, 4'd0, 4'd9, 4'd1, 4'd0}};
        tab[5] = '{6'b001000, 4, {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}};
        tab[6] = '{6'b111111, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};
        tab[7] = '{6'b001101, 2, {4'd0, 4'd0, 4'd0, 4'd1, 4'd0}};

        reset = 1'b1;
        Op    = 6'b000000;
        #1;
        chk("reset_state", 32'(State), 32'd0);
        chk("reset_outs", 32'(w_outs), 32'(OUT_RESET));
        chk("reset_count", 32'(InstrCount), 32'd0);
        chk("reset_illegal", 32'(Illegal), 32'd0);
        repeat (2) @(negedge clk);
        chk("reset_hold_state", 32'(State), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++)
            run_seq(tab[i].op, tab[i].len, tab[i].seq, 1'b0);

        start_cnt = model_cnt;
        run_op(6'b000000, 1'b0);
        run_op(6'b101011, 1'b0);
        run_op(6'b000100, 1'b0);
        run_op(6'b000010, 1'b0);
        run_op(6'b001000, 1'b0);
        #1;
        chk("burst_retired", 32'(InstrCount), 32'(start_cnt + 5));

        // Opcode switches to sw while in MEMRD: the load still completes, no memory write.
        Op = 6'b100011;
        check_cycle(4'd0, Op); @(negedge clk);
        check_cycle(4'd1, Op); @(negedge clk);
        check_cycle(4'd2, Op); @(negedge clk);
        Op = 6'b101011;
        check_cycle(4'd3, Op); @(negedge clk);
        check_cycle(4'd4, Op);
        chk("late_op_memwrite", 32'(MemWrite), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 7))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'($urandom);
            endcase
            run_op(op, 1'b1);
        end

        // Reset while in EXEC: abort, clear the counter, then resume from FETCH.
        Op = 6'b000000;
        check_cycle(4'd0, Op); @(negedge clk);
        check_cycle(4'd1, Op); @(negedge clk);
        check_cycle(4'd6, Op);
        reset = 1'b1;
        model_cnt = 0;
        #1;
        chk("midexec_state", 32'(State), 32'd0);
        chk("midexec_outs", 32'(w_outs), 32'(OUT_RESET));
        chk("midexec_count", 32'(InstrCount), 32'd0);
        chk("midexec_small_count", 32'(s_InstrCount), 32'd0);
        repeat (2) @(negedge clk);
        chk("midexec_hold_outs", 32'(w_outs), 32'(OUT_RESET));
        reset = 1'b0;
        check_cycle(4'd0, Op); @(negedge clk);
        check_cycle(4'd1, Op); @(negedge clk);
        check_cycle(4'd6, Op); @(negedge clk);
        check_cycle(4'd7, Op); @(negedge clk);

        // Run jumps past the narrow counter's wrap point.
        while (model_cnt != 15) run_op(6'b000010, 1'b1);
        run_op(6'b000010, 1'b1);
        #1;
        chk("wrap_small", 32'(s_InstrCount), 32'd0);
        chk("wrap_main", 32'(InstrCount), 32'd16);
        run_op(6'b000010, 1'b0);
        check_cycle(4'd0, Op);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
